div_counter_bank: RTL

Multi-channel, parametrised counter bank that counts positive-and-valid `divisible` results from up to `NUM_CH` divisibility checker instances. It sits beside the checkers on the shared register bus. It exposes per-channel counters, a control register and a sticky overflow status register, and drives one overflow interrupt. It adds wrap/saturate mode, overflow detection, a global enable, and optional clear-on-read over the single-counter design.

---
 rtl/div_counter_bank.sv | 131 +++++++++++++
 1 files changed

// File: rtl/div_counter_bank.sv
// Multi-channel counter bank for divisibility-checker results, with CTRL/STATUS registers and overflow IRQ.
// Optional build macro DIV_CNT_CLR_ON_RD_EN: a bus read of CNT[i] clears that counter.
module div_counter_bank #(
    parameter int                     REG_ADDR_SZ = 8,
    parameter int                     REG_DATA_SZ = 32,
    parameter int                     NUM_CH      = 4,
    parameter int                     CNT_W       = 16,
    parameter logic [REG_ADDR_SZ-1:0] BASE_ADDR   = REG_ADDR_SZ'(5)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CH-1:0]      divisible,
    input  logic [NUM_CH-1:0]      result_vld,
    input  logic                   reg_rd_en,
    input  logic                   reg_wr_en,
    input  logic [REG_ADDR_SZ-1:0] reg_addr,
    input  logic [REG_DATA_SZ-1:0] reg_wr_data,
    output logic [REG_DATA_SZ-1:0] reg_rd_data,
    output logic                   ovf_irq
);

    localparam logic [REG_ADDR_SZ-1:0] CTRL_ADDR = BASE_ADDR + REG_ADDR_SZ'(NUM_CH);
    localparam logic [REG_ADDR_SZ-1:0] STAT_ADDR = BASE_ADDR + REG_ADDR_SZ'(NUM_CH + 1);
    localparam logic [CNT_W-1:0]       CNT_MAX   = '1;

    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic              en_q, en_d;
    logic              sat_q, sat_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0] status_q, status_d;
    logic [NUM_CH-1:0] ovf_set;
    logic [NUM_CH-1:0] inc;
    logic [NUM_CH-1:0] cnt_wr;
    logic              ctrl_wr;
    logic              stat_wr;
    logic              unused_wr_data;

    assign unused_wr_data = ^reg_wr_data;
    assign inc     = {NUM_CH{en_q}} & divisible & result_vld;
    assign ctrl_wr = reg_wr_en && (reg_addr == CTRL_ADDR);
    assign stat_wr = reg_wr_en && (reg_addr == STAT_ADDR);

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_wr[i] = reg_wr_en && (reg_addr == BASE_ADDR + REG_ADDR_SZ'(i));
        end
    end

`ifdef DIV_CNT_CLR_ON_RD_EN
    logic [NUM_CH-1:0] cnt_rd;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_rd[i] = reg_rd_en && (reg_addr == BASE_ADDR + REG_ADDR_SZ'(i));
        end
    end
`endif

    // Priority per channel: bus write, then read-clear (if built in), then increment.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            cnt_d[i]   = cnt_q[i];
            ovf_set[i] = 1'b0;
            if (cnt_wr[i]) begin
                cnt_d[i] = reg_wr_data[CNT_W-1:0];
            end
`ifdef DIV_CNT_CLR_ON_RD_EN
            else if (cnt_rd[i]) begin
                cnt_d[i] = inc[i] ? CNT_W'(1) : '0;
            end
`endif
            else if (inc[i]) begin
                if (cnt_q[i] != CNT_MAX) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end else begin
                    ovf_set[i] = 1'b1;
                    cnt_d[i]   = sat_q ? CNT_MAX : '0;
                end
            end
        end
    end

    // A new overflow outranks a coincident write-1-to-clear on the same bit.
    always_comb begin
        en_d     = ctrl_wr ? reg_wr_data[0] : en_q;
        sat_d    = ctrl_wr ? reg_wr_data[1] : sat_q;
        mask_d   = ctrl_wr ? reg_wr_data[NUM_CH+1:2] : mask_q;
        status_d = (status_q & ~(stat_wr ? reg_wr_data[NUM_CH-1:0] : '0)) | ovf_set;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= '0;
            end
            en_q     <= 1'b1;
            sat_q    <= 1'b0;
            mask_q   <= '1;
            status_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            en_q     <= en_d;
            sat_q    <= sat_d;
            mask_q   <= mask_d;
            status_q <= status_d;
        end
    end

    always_comb begin
        reg_rd_data = '0;
        if (reg_rd_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (reg_addr == BASE_ADDR + REG_ADDR_SZ'(i)) begin
                    reg_rd_data[CNT_W-1:0] = cnt_q[i];
                end
            end
            if (reg_addr == CTRL_ADDR) begin
                reg_rd_data[NUM_CH+1:0] = {mask_q, sat_q, en_q};
            end
            if (reg_addr == STAT_ADDR) begin
                reg_rd_data[NUM_CH-1:0] = status_q;
            end
        end
    end

    assign ovf_irq = |(status_q & mask_q);

endmodule
